div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port Start_i, input, 1, request to begin a divide/remainder op.
REQ-005 SHALL have port Funct3_i, input, 3, op select: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port SrcA_i, input, DATA_WIDTH, dividend.
REQ-007 SHALL have port SrcB_i, input, DATA_WIDTH, divisor.
REQ-008 SHALL have port Flush_i, input, 1, abort the in-flight op.
REQ-009 SHALL have port Busy_o, output, 1, pipeline stall request while an op is in progress.
REQ-010 SHALL have port Done_o, output, 1, one-cycle pulse marking Result_o valid.
REQ-011 SHALL have port Result_o, output, DATA_WIDTH, quotient or remainder.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 SHALL accept Start_i only in IDLE or DONE and only when Funct3_i[2]=1; otherwise Start_i is ignored.
REQ-014 SHALL latch SrcA_i, SrcB_i and Funct3_i at the accepting edge; later input changes have no effect on the op.
REQ-015 SHALL, for signed ops (Funct3_i[0]=0), convert operands to magnitudes and record the signs at acceptance.
REQ-016 SHALL in CALC perform one restoring-division iteration per cycle for exactly DATA_WIDTH cycles, counted by an iteration counter from 0 to DATA_WIDTH-1.
REQ-017 SHALL in FIX apply sign correction: quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-018 SHALL, for start accepted at edge N, be in CALC for cycles N+1..N+DATA_WIDTH, FIX at N+DATA_WIDTH+1, DONE at N+DATA_WIDTH+2.
REQ-019 SHALL drive Busy_o=1 in CALC and FIX and Busy_o=0 in IDLE and DONE.
REQ-020 SHALL drive Done_o=1 only in DONE, for exactly one cycle per completed op.
REQ-021 SHALL hold Result_o from DONE until the next op reaches DONE.
REQ-022 SHALL, on divisor zero, produce quotient all ones and remainder equal to the dividend, for both signed and unsigned ops.
REQ-023 SHALL, on signed overflow (dividend = most-negative value, divisor = -1), produce quotient equal to the dividend and remainder 0.
REQ-024 SHALL return from DONE to IDLE unless a new start is accepted in DONE, in which case it enters CALC back-to-back.
REQ-025 SHALL, when Flush_i=1, go to IDLE at the next edge from any state, with no Done_o and Result_o unchanged.
REQ-026 SHALL give Flush_i priority over a simultaneous Start_i, leaving no op accepted.

Reset
REQ-027 SHALL, while rst=1, force state IDLE, Busy_o=0, Done_o=0, Result_o=0, counter and operand registers 0, independent of clk.
REQ-028 SHALL abandon any in-flight op when rst asserts mid-operation; no Done_o follows reset release.

Configuration
REQ-029 SHALL, with DIV_FAST_SPECIAL_EN defined, route divide-by-zero and signed-overflow ops from IDLE/DONE directly to DONE, so Done_o asserts at N+1 with Busy_o never asserted.
REQ-030 SHALL, without DIV_FAST_SPECIAL_EN, take the full DATA_WIDTH+2 latency for special cases with identical result values.

Verification
REQ-031 SHALL cover DIV 20 / -3 -> Result_o=0xFFFFFFFA, Done_o one cycle at N+34, Busy_o high N+1..N+33.
REQ-032 SHALL cover REM -20 / 3 -> 0xFFFFFFFE; REMU 0xFFFFFFEC / 3 -> 0x00000002.
REQ-033 SHALL cover DIVU 7 / 0 -> 0xFFFFFFFF and REMU 7 / 0 -> 7, at N+1 with the macro and N+34 without.
REQ-034 SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM of the same -> 0.
REQ-035 SHALL cover Flush_i at the 10th CALC cycle -> Busy_o=0 next cycle, no Done_o, and a Start_i the following cycle completes normally.
REQ-036 SHALL cover rst pulsed mid-CALC -> all outputs 0 immediately, no Done_o after release, and a back-to-back Start_i in DONE accepted.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Build option DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish in a single cycle.
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start_i,
  input  logic [2:0]            Funct3_i,
  input  logic [DATA_WIDTH-1:0] SrcA_i,
  input  logic [DATA_WIDTH-1:0] SrcB_i,
  input  logic                  Flush_i,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic [DATA_WIDTH-1:0] Result_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] quo_q;      // dividend magnitude shifts out, quotient bits shift in
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] dvs_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  is_rem_q;
  logic                  neg_quo_q;
  logic                  neg_rem_q;
  logic                  div_zero_q;

  logic                  is_signed;
  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic                  div_zero;
  logic                  accept;
  logic [DATA_WIDTH:0]   trial;
  logic [DATA_WIDTH-1:0] quo_fix;
  logic [DATA_WIDTH-1:0] rem_fix;
  logic [DATA_WIDTH-1:0] fix_res;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latches).
  always_comb begin
    is_signed = ~Funct3_i[0];
    a_neg     = is_signed & SrcA_i[DATA_WIDTH-1];
    b_neg     = is_signed & SrcB_i[DATA_WIDTH-1];
    a_mag     = a_neg ? -SrcA_i : SrcA_i;
    b_mag     = b_neg ? -SrcB_i : SrcB_i;
    div_zero  = (SrcB_i == '0);
    accept    = ((state_q == IDLE) || (state_q == DONE)) && Start_i && Funct3_i[2] && !Flush_i;
  end

`ifdef DIV_FAST_SPECIAL_EN
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

  logic                  overflow;
  logic                  special;
  logic [DATA_WIDTH-1:0] special_res;

  always_comb begin
    overflow    = is_signed && (SrcA_i == MOST_NEG) && (SrcB_i == '1);
    special     = div_zero | overflow;
    special_res = '0;
    if (div_zero) special_res = Funct3_i[1] ? SrcA_i : '1;
    else          special_res = Funct3_i[1] ? '0 : SrcA_i;
  end
`endif

  // Restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
  always_comb begin
    trial   = {rem_q, quo_q[DATA_WIDTH-1]} - {1'b0, dvs_q};
    quo_fix = div_zero_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
    rem_fix = neg_rem_q ? -rem_q : rem_q;
    fix_res = is_rem_q ? rem_fix : quo_fix;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
`ifdef DIV_FAST_SPECIAL_EN
          state_d = special ? DONE : CALC;
`else
          state_d = CALC;
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC:    if (cnt_q == LAST_ITER) state_d = FIX;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (Flush_i) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the datapath registers are reset too, so an aborted op leaves no residue visible after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      result_q   <= '0;
      is_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q      <= '0;
        quo_q      <= a_mag;
        rem_q      <= '0;
        dvs_q      <= b_mag;
        is_rem_q   <= Funct3_i[1];
        neg_quo_q  <= a_neg ^ b_neg;
        neg_rem_q  <= a_neg;
        div_zero_q <= div_zero;
`ifdef DIV_FAST_SPECIAL_EN
        if (special) result_q <= special_res;
`endif
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + 1'b1;
        if (!trial[DATA_WIDTH]) begin
          rem_q <= trial[DATA_WIDTH-1:0];
          quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          rem_q <= {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]};
          quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b0};
        end
      end else if ((state_q == FIX) && !Flush_i) begin
        result_q <= fix_res;
      end
    end
  end

  assign Busy_o   = (state_q == CALC) || (state_q == FIX);
  assign Done_o   = (state_q == DONE);
  assign Result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against a cycle-latency reference model.
// Latency expectations follow DIV_FAST_SPECIAL_EN when the bench is built with it.
module tb_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;
`ifdef DIV_FAST_SPECIAL_EN
  localparam int LAT_SPECIAL = 1;
  localparam bit FAST        = 1'b1;
`else
  localparam int LAT_SPECIAL = LAT;
  localparam bit FAST        = 1'b0;
`endif

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;
  localparam logic [W-1:0] MOST_NEG = 32'h8000_0000;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   f3    = 3'b000;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  div_unit #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .Start_i  (start),
    .Funct3_i (f3),
    .SrcA_i   (a),
    .SrcB_i   (b),
    .Flush_i  (flush),
    .Busy_o   (busy),
    .Done_o   (done),
    .Result_o (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result from plain integer arithmetic (truncating division).
  function automatic logic [W-1:0] ref_op(input logic [2:0] fn, input logic [W-1:0] x, input logic [W-1:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    if (y == '0) return fn[1] ? x : '1;
    if (!fn[0]) begin
      sx = $signed(x);
      sy = $signed(y);
      return W'(fn[1] ? (sx % sy) : (sx / sy));
    end
    ux = 64'(x);
    uy = 64'(y);
    return W'(fn[1] ? (ux % uy) : (ux / uy));
  endfunction

  function automatic bit is_special(input logic [2:0] fn, input logic [W-1:0] x, input logic [W-1:0] y);
    return (y == '0) || (!fn[0] && (x == MOST_NEG) && (y == '1));
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return W'(1);
      2:       return '1;
      3:       return MOST_NEG;
      4:       return W'($urandom_range(0, 20));
      5:       return -W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Reference model: remaining busy cycles, done flag and held result.
  int           m_left   = 0;
  logic         m_done   = 1'b0;
  logic [W-1:0] m_result = '0;
  logic [W-1:0] m_pend   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left   <= 0;
      m_done   <= 1'b0;
      m_result <= '0;
    end else if (flush) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else if ((m_left == 0) && start && f3[2]) begin
      if (FAST && is_special(f3, a, b)) begin
        m_done   <= 1'b1;
        m_result <= ref_op(f3, a, b);
      end else begin
        m_left <= LAT - 1;
        m_pend <= ref_op(f3, a, b);
        m_done <= 1'b0;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) m_result <= m_pend;
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", W'(busy), W'(m_left != 0));
      check("done", W'(done), W'(m_done));
      check("result", result, m_result);
    end
  end

  // Caller sits just after a rising edge; start is held for exactly one edge, then inputs are scrambled.
  task automatic issue(input logic [2:0] fn, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    f3    = fn;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    f3    = 3'($urandom);
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  // Counts cycles after the accepting edge until Done_o; returns in the DONE cycle.
  task automatic wait_done(input string name, input int exp_lat, input logic [W-1:0] exp_res);
    int k    = 0;
    bit seen = 1'b0;
    while (!seen && (k < 80)) begin
      @(negedge clk);
      k++;
      seen = done;
    end
    check({name, " latency"}, W'(seen ? k : 0), W'(exp_lat));
    check({name, " value"}, result, exp_res);
  endtask

  task automatic run_op(input string name, input logic [2:0] fn, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int exp_lat, input logic [W-1:0] exp_res);
    @(posedge clk);
    #1;
    issue(fn, x, y);
    wait_done(name, exp_lat, exp_res);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;

    // Model pinned to hand-computed values.
    check("model DIV 20/-3", ref_op(F_DIV, 32'd20, -32'd3), 32'hFFFF_FFFA);
    check("model REMU", ref_op(F_REMU, 32'hFFFF_FFEC, 32'd3), 32'h0000_0002);
    check("model DIV ovf", ref_op(F_DIV, MOST_NEG, '1), 32'h8000_0000);
    check("model DIV -7/0", ref_op(F_DIV, -32'd7, '0), 32'hFFFF_FFFF);

    #12;
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    check("reset result", result, '0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op("DIV 20/-3", F_DIV, 32'd20, -32'd3, LAT, 32'hFFFF_FFFA);
    run_op("REM -20/3", F_REM, -32'd20, 32'd3, LAT, 32'hFFFF_FFFE);
    run_op("REMU ffffffec/3", F_REMU, 32'hFFFF_FFEC, 32'd3, LAT, 32'h0000_0002);
    run_op("DIVU 7/0", F_DIVU, 32'd7, '0, LAT_SPECIAL, 32'hFFFF_FFFF);
    run_op("REMU 7/0", F_REMU, 32'd7, '0, LAT_SPECIAL, 32'h0000_0007);
    run_op("DIV -7/0", F_DIV, -32'd7, '0, LAT_SPECIAL, 32'hFFFF_FFFF);
    run_op("REM -7/0", F_REM, -32'd7, '0, LAT_SPECIAL, 32'hFFFF_FFF9);
    run_op("DIV ovf", F_DIV, MOST_NEG, '1, LAT_SPECIAL, 32'h8000_0000);
    run_op("REM ovf", F_REM, MOST_NEG, '1, LAT_SPECIAL, 32'h0000_0000);
    run_op("DIVU 1000/7", F_DIVU, 32'd1000, 32'd7, LAT, 32'd142);

    // Non-divide funct3 and start coinciding with flush are both ignored.
    @(posedge clk);
    #1;
    issue(3'b011, 32'd9, 32'd3);
    check("ignored funct3 busy", W'(busy), '0);
    start = 1'b1;
    flush = 1'b1;
    f3    = F_DIV;
    a     = 32'd9;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush beats start", W'(busy), '0);

    // Flush during the tenth CALC cycle, then a fresh op the following cycle.
    issue(F_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush busy drop", W'(busy), '0);
    check("flush keeps result", result, 32'd142);
    issue(F_REM, 32'd100, 32'd7);
    wait_done("after flush", LAT, 32'd2);

    // Reset mid-CALC: outputs clear at once and the abandoned op never completes.
    @(posedge clk);
    #1;
    issue(F_DIVU, 32'd500, 32'd3);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid rst busy", W'(busy), '0);
    check("mid rst done", W'(done), '0);
    check("mid rst result", result, '0);
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | done;
    end
    check("no done after rst", W'(seen), '0);

    // Back-to-back: the second start arrives during the first op's DONE cycle.
    run_op("b2b first", F_DIVU, 32'd81, 32'd9, LAT, 32'd9);
    start = 1'b1;
    f3    = F_REMU;
    a     = 32'd83;
    b     = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("b2b second", LAT, 32'd2);

    // Randomized traffic, including ignored starts, specials and occasional flushes.
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #1;
      start = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 99) == 0);
      f3    = 3'($urandom);
      a     = rand_operand();
      b     = rand_operand();
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
